// File: rtl/ex_div_pkg.sv
// Shared types and handshake constants for the execute-stage divider.
// The execute stage and stall controller use the same handshake constants.
package ex_div_pkg;

  localparam int unsigned DivWidth  = 32;
  localparam int unsigned CntWidth  = 6;
  localparam int unsigned RemWidth  = DivWidth + 1;
  localparam int unsigned WorkWidth = 2 * DivWidth + 1;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef struct packed {
    logic [DivWidth-1:0] rem;
    logic [DivWidth-1:0] quot;
  } div_result_t;

  // Two's-complement negate when neg is set, identity otherwise.
  function automatic logic [DivWidth-1:0] div_cond_neg(input logic [DivWidth-1:0] v,
                                                       input logic                neg);
    return neg ? (~v + DivWidth'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign-magnitude handling around an unsigned core, flush abort via annul_i.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DivWidth-1:0]   opdata1_i,
  input  logic [DivWidth-1:0]   opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DivWidth-1:0] result_o,
  output logic                  ready_o
);

  div_state_e            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [WorkWidth-1:0]  work_q, work_d;
  logic [DivWidth-1:0]   divisor_q, divisor_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  div_result_t           result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  accept_c;
  logic                  abort_c;
  logic                  divisor_zero_c;
  logic                  op1_neg_c;
  logic                  op2_neg_c;
  logic                  cnt_done_c;
  logic [RemWidth-1:0]   rem_shift_c;
  logic [RemWidth-1:0]   rem_sub_c;
  logic                  rem_ge_c;
  logic [WorkWidth-1:0]  step_c;
  div_result_t           fixed_c;

  assign accept_c       = (start_i == DivStart) && !annul_i;
  assign abort_c        = annul_i || (start_i == DivStop);
  assign divisor_zero_c = (opdata2_i == '0);
  assign op1_neg_c      = signed_div_i & opdata1_i[DivWidth-1];
  assign op2_neg_c      = signed_div_i & opdata2_i[DivWidth-1];
  assign cnt_done_c     = (cnt_q == CntWidth'(DivWidth));

  // Restoring step: shift {rem, dividend} left, subtract divisor when it fits.
  // A carry out of the shifted remainder also forces the subtract.
  assign rem_shift_c = work_q[WorkWidth-2:DivWidth-1];
  assign rem_ge_c    = work_q[WorkWidth-1] | (rem_shift_c >= {1'b0, divisor_q});
  assign rem_sub_c   = rem_shift_c - {1'b0, divisor_q};
  assign step_c      = rem_ge_c ? {rem_sub_c, work_q[DivWidth-2:0], 1'b1}
                                : {rem_shift_c, work_q[DivWidth-2:0], 1'b0};

  // Quotient sign follows operand sign mismatch; remainder follows dividend.
  assign fixed_c.quot = div_cond_neg(work_q[DivWidth-1:0], neg_quot_q);
  assign fixed_c.rem  = div_cond_neg(work_q[2*DivWidth-1:DivWidth], neg_rem_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivFree: begin
        if (accept_c) begin
          state_d = divisor_zero_c ? DivByZero : DivOn;
        end
      end
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (abort_c) begin
          state_d = DivFree;
        end else if (cnt_done_c) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (abort_c) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (accept_c && !divisor_zero_c) begin
          cnt_d      = '0;
          work_d     = {RemWidth'(0), div_cond_neg(opdata1_i, op1_neg_c)};
          divisor_d  = div_cond_neg(opdata2_i, op2_neg_c);
          neg_quot_d = op1_neg_c ^ op2_neg_c;
          neg_rem_d  = op1_neg_c;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (abort_c) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (!cnt_done_c) begin
          work_d = step_c;
          cnt_d  = cnt_q + CntWidth'(1);
        end else begin
          result_d = fixed_c;
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (abort_c) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Randomized scoreboard bench for ex_div: driver pushes expected results
// and ready cycles, an independent monitor pops on every ready_o rise.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Arithmetic reference: truncating division, remainder takes dividend's sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pop on ready rise, check value and cycle; check hold while high.
  logic prev_ready = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_ready: cycle=%0d result=%h, no result expected", cyc, result_o);
      end else begin
        cur = sb.pop_front();
        if (result_o !== cur.res) begin
          bad++;
          $display("FAIL result: got %h want %h", result_o, cur.res);
        end
        total++;
        if (cyc != cur.t) begin
          bad++;
          $display("FAIL ready_cycle: got %0d want %0d", cyc, cur.t);
        end
      end
    end else if (ready_o && prev_ready) begin
      total++;
      if (result_o !== cur.res) begin
        bad++;
        $display("FAIL result_hold: got %h want %h", result_o, cur.res);
      end
    end
    prev_ready = ready_o;
  end

  task automatic check_idle(input string name);
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL %s: ready=%b result=%h want ready=0 result=0", name, ready_o, result_o);
    end
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = model(sgn, a, b);
    e.t   = cyc + ((b == 32'd0) ? 2 : 34);
    sb.push_back(e);
    @(posedge clk); #1;
    // Operand changes after accept must not matter.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 40);
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL timeout: ready=%b after %0d cycles, want 1", ready_o, n);
      start_i = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check_idle("ready_drop");
  endtask

  // Start an operation, kill it at T+10 with annul or reset, confirm FREE.
  task automatic do_abort(input logic use_rst);
    @(posedge clk); #1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start_i = 1'b0;
    if (use_rst) rst = 1'b1;
    else annul_i = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    annul_i = 1'b0;
    check_idle(use_rst ? "after_rst" : "after_annul");
    repeat (40) @(posedge clk);
    #1;
    check_idle(use_rst ? "no_ready_rst" : "no_ready_annul");
    do_op(1'b0, 32'd9, 32'd3, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    int          mode;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 2);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1);
    do_op(1'b0, 32'd1234, 32'd0, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 32'd77, 32'd0, 3);

    do_abort(1'b0);
    do_abort(1'b1);

    // annul together with start in FREE must block the accept.
    @(posedge clk); #1;
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_idle("annul_beats_start");

    for (int i = 0; i < 45; i++) begin
      mode = $urandom_range(0, 7);
      a = $urandom;
      case (mode)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom >> $urandom_range(1, 28);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (b == 32'd0 && mode != 0) b = 32'd1;
      if (mode == 4) a = 32'h8000_0000;
      do_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Execute-stage logic (fed by the ID/EX pipeline register) presents operands with a start request and holds the pipeline stalled while the divider runs. The divider returns {remainder, quotient} for the HI/LO write path. It is a radix-2, one-bit-per-cycle restoring divider with signed and unsigned modes and a flush abort.

## Interface
Parameters: none (width fixed at 32).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
- opdata1_i  in  32  dividend; sampled at accept
- opdata2_i  in  32  divisor; sampled at accept
- start_i  in  1  request; held high by execute stage until ready_o seen
- annul_i  in  1  abort (pipeline flush or exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1
- ready_o  out  1  result valid

## Operation
- States: FREE, BYZERO, ON, END. Reset -> FREE, result_o=0, ready_o=0, cnt=0.
- FREE: if start_i=1 and annul_i=0:
  - divisor=0 -> BYZERO;
  - else -> ON, with operands latched (absolute values if signed), cnt=0, partial remainder=0.
  Otherwise remain FREE with outputs 0.
- BYZERO: next edge -> END with quotient=0, remainder=0.
- ON, annul_i=0, start_i=1:
  - cnt<32: one restoring step (shift {rem,dividend} left 1; if rem≥divisor subtract, set quotient bit); cnt+1.
  - cnt=32: sign fix-up, register result_o, ready_o=1, -> END.
- ON with annul_i=1 or start_i=0: -> FREE, result_o=0, ready_o=0; partial result discarded.
- END: hold result_o and ready_o=1 while start_i=1; start_i=0 -> FREE, result_o=0, ready_o=0. annul_i=1 in END -> FREE.
- Signed fix-up: quotient negated if operand signs differ; remainder carries dividend's sign.
- 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0; no trap, no flag.
- Operand changes after accept are ignored.
- annul_i has priority over start_i in every state; rst has priority over all.

## Timing
- Accept at edge closing cycle T (FREE, start_i=1).
- Normal path:
  - Iteration steps at edges closing T+1..T+32.
  - Fix-up at edge closing T+33.
  - ready_o=1 and result_o valid from cycle T+34.
- Divide by zero: ready_o=1 from cycle T+2.
- Execute stage deasserts start_i the cycle it samples ready_o=1. Next edge -> FREE, ready_o=0.
- A new start_i is accepted no earlier than the following cycle, giving one idle FREE cycle between operations.
- Outputs are registered only; no combinational path from inputs to ready_o/result_o.
- Reset mid-operation: next edge FREE, all outputs 0, no residual result.

## Structure
- State encodings (DivFree, DivByZero, DivOn, DivEnd) go in the shared defines file.
- Handshake constants (DivStart, DivStop, DivResultReady, DivResultNotReady) also go in the shared defines file.
- Execute stage and stall controller consume these constants too.
- Single flat module: one state register, 6-bit cnt, 65-bit working register, 32-bit latched divisor, latched sign bits.
- No sub-module; the iteration step is a local subtract/compare.

## Test plan
- Unsigned 100/7, start held: ready_o first high at T+34; result_o = {0x00000002, 0x0000000E}. Drop start_i: ready_o=0 next cycle.
- Signed −100/7 (0xFFFFFF9C, 7): quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
- Unsigned 0xFFFFFFFF/2: quotient 0x7FFFFFFF, remainder 1. Same operands signed (−1/2): quotient 0, remainder 0xFFFFFFFF.
- Divisor 0 (opdata1=1234): ready_o high at T+2, result_o=0.
- Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0 at T+34.
- annul_i pulse at T+10: FREE at T+11, ready_o never asserts. Then 9/3 returns {0, 3} at its own T'+34. Repeat with rst at T+10: same recovery.
